// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared width, op encoding and state definitions for the HI/LO multiply/divide unit
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_t;
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on the {hi,lo} accumulator
// divide path present only when MULDIV_DIV_EN is defined
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
`ifdef MULDIV_DIV_EN
  input  logic              is_div,
`endif
  output logic [2*XLEN-1:0] nxt
);
  logic [XLEN:0] sum;
  logic [2*XLEN-1:0] mul_n;
  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_n = {sum, acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
  logic [XLEN:0] diff;
  logic [2*XLEN-1:0] div_n;
  // remainder shifted left needs XLEN+1 bits before the trial subtract
  assign diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  assign div_n = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign nxt = is_div ? div_n : mul_n;
`else
  assign nxt = mul_n;
`endif
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; DIV/DIVU need MULDIV_DIV_EN
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            rd_hilo,
  input  logic            sel_hi,
  output logic [XLEN-1:0] hilo_out,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            divzero
);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_n, res;
  logic [XLEN-1:0] a, b, opnd, hi, lo, ua, ub;
  logic sgn, neg, sa, sb, accept;
  assign sa = sgn & a[XLEN-1];
  assign sb = sgn & b[XLEN-1];
  assign ua = sa ? -a : a;
  assign ub = sb ? -b : b;
`ifdef MULDIV_DIV_EN
  logic dv, negr, divz;
  assign accept = start & (state == S_IDLE);
  assign res = !dv ? (neg ? -acc : acc) :
               divz ? {a, {XLEN{1'b1}}} :
               {negr ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN], neg ? -acc[XLEN-1:0] : acc[XLEN-1:0]};
  assign divzero = done & dv & divz;
  muldiv_step u_step (.acc(acc), .opnd(opnd), .is_div(dv), .nxt(acc_n));
`else
  assign accept = start & (state == S_IDLE) & ~op[1];
  assign res = neg ? -acc : acc;
  assign divzero = 1'b0;
  muldiv_step u_step (.acc(acc), .opnd(opnd), .nxt(acc_n));
`endif
  assign busy = state != S_IDLE;
  assign stall = (start | rd_hilo) & busy;
  assign done = state == S_FIX;
  assign hilo_out = sel_hi ? hi : lo;
  always_comb begin
    nxt = state == S_IDLE ? (accept ? S_PREP : S_IDLE) :
          state == S_PREP ? S_RUN :
          state == S_RUN  ? (cnt == '0 ? S_FIX : S_RUN) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        a <= srca;
        b <= srcb;
        sgn <= ~op[0];
`ifdef MULDIV_DIV_EN
        dv <= op[1];
`endif
      end
      if (state == S_PREP) begin
        cnt <= CW'(XLEN - 1);
        neg <= sa ^ sb;
`ifdef MULDIV_DIV_EN
        negr <= sa;
        divz <= b == '0;
        acc <= {{XLEN{1'b0}}, dv ? ua : ub};
        opnd <= dv ? ub : ua;
`else
        acc <= {{XLEN{1'b0}}, ub};
        opnd <= ua;
`endif
      end
      if (state == S_RUN) begin
        acc <= acc_n;
        cnt <= cnt - 1'b1;
      end
      if (state == S_FIX) {hi, lo} <= res;
    end
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer owning the HI/LO register pair for the MIPS core. It accepts MULT/MULTU/DIV/DIVU issued by the decode stage and runs a 32-step shift-add or restoring-divide sequence. It exposes HI/LO to the mfhi/mflo path and stalls the core when a HI/LO read or a new operation arrives while a sequence is in progress.

## Interface
- XLEN, 32, operand/HI/LO width; iteration count equals XLEN
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  issue request for op with srca/srcb
- op  in  2  funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srca  in  XLEN  rs operand (multiplicand/dividend)
- srcb  in  XLEN  rt operand (multiplier/divisor)
- rd_hilo  in  1  mfhi/mflo in decode
- sel_hi  in  1  1 = read HI, 0 = read LO
- hilo_out  out  XLEN  combinational: sel_hi ? HI : LO
- busy  out  1  high in any state except IDLE
- stall  out  1  (start | rd_hilo) & busy
- done  out  1  one-cycle pulse in the cycle HI/LO are written
- divzero  out  1  pulses with done when a DIV/DIVU had srcb == 0

## Operation
- States: IDLE, PREP, RUN, FIX.
- IDLE: start sampled high → latch op, srca, srcb → PREP. start while busy is ignored; stall holds the issuing instruction.
- PREP: signed ops take absolute values and record result signs (product: sa^sb; quotient: sa^sb; remainder: sa). Load the iteration counter with XLEN-1. → RUN.
- RUN: one step per cycle for exactly XLEN cycles.
  - Multiply: 2*XLEN-bit accumulator, add-if-LSB then shift right.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Counter reaches 0 → FIX.
- FIX: apply two's-complement sign correction, write HI/LO, pulse done → IDLE.
- Multiply results: HI/LO = full 64-bit product.
- Divide results: LO = quotient, HI = remainder, truncating toward zero.
- Divisor 0, either signedness: LO = 0xFFFFFFFF, HI = srca, divzero pulses.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- HI/LO change only in FIX or on reset.

## Timing
- start accepted at cycle t. PREP at t+1. RUN t+2..t+33. FIX t+34 with done=1. IDLE at t+35.
- busy is high t+1..t+34. New results are visible on hilo_out from t+35.
- rd_hilo at any cycle in t+1..t+34 → stall=1 through t+34. stall=0 at t+35 with the new value.
- Back-to-back: a start held by stall is accepted at t+35. Operands must remain stable, as guaranteed by the stalled pipeline.
- Reset values: state IDLE, HI=LO=0, busy=0, stall=0, done=0, divzero=0.
- Reset mid-operation abandons the sequence. The next cycle is IDLE with HI=LO=0 and no done pulse.
- reset and start in the same cycle: reset wins, start is dropped.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU are supported as above.
- Without MULDIV_DIV_EN:
  - The divide datapath is removed.
  - start with op[1]=1 is ignored: state stays IDLE, HI/LO unchanged, no done.
  - divzero is tied to 0.

## Structure
- Package muldiv_pkg holds:
  - XLEN default
  - op encoding enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state enum (S_IDLE, S_PREP, S_RUN, S_FIX)
  - counter width constant $clog2(XLEN)
- One combinational sub-module, muldiv_step: takes accumulator, operand and op class, and returns the next accumulator for one multiply or divide iteration.
- The FSM, counter, sign handling and HI/LO registers stay in muldiv_unit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done exactly at t+34; busy low at t+35.
- MULT 0xFFFFFFFD × 0x00000007 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7 → LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234; divzero pulse at t+34.
- rd_hilo=1, sel_hi=0 held from t+5:
  - stall=1 for t+5..t+34, stall=0 at t+35.
  - hilo_out equals the new LO at t+35.
  - A second start at t+3 is not accepted until t+35.
- reset at t+10 of a MULT → IDLE at t+11, HI=LO=0, no done.
- With MULDIV_DIV_EN undefined, a DIVU start leaves busy=0 and HI/LO unchanged.
